// File: rtl/bcd_calc_core.sv
// Keypad calculator core: collects two BCD operands and an operator from PS/2 key strobes,
// then runs add/sub/mul on one shared BCD adder. Optional Backspace via CALC_BACKSPACE_EN.
module bcd_calc_core #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_valid,
   input  logic [8:0]            key_code,
   output logic [8*DIGITS-1:0]   disp_bcd,
   output logic                  disp_neg,
   output logic [1:0]            disp_op,
   output logic [2:0]            state,
   output logic                  busy
);

   localparam int OW = 4*DIGITS;
   localparam int RW = 8*DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS-1);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_CALC    = 3'd2,
      S_SHOW    = 3'd3
   } state_t;

   typedef enum logic [2:0] {
      K_NONE  = 3'd0,
      K_DIGIT = 3'd1,
      K_OP    = 3'd2,
      K_ENTER = 3'd3,
      K_BS    = 3'd4
   } key_t;

   // Tens-complement add/subtract over the full result width; carry out is discarded.
   function automatic logic [RW-1:0] bcd_addsub(input logic [RW-1:0] a,
                                                input logic [RW-1:0] b,
                                                input logic          sub);
      logic [4:0]    s;
      logic [3:0]    bd;
      logic          c;
      logic [RW-1:0] r;
      c = sub;
      r = '0;
      for (int i = 0; i < 2*DIGITS; i++) begin
         bd = sub ? (4'd9 - b[4*i +: 4]) : b[4*i +: 4];
         s  = {1'b0, a[4*i +: 4]} + {1'b0, bd} + {4'd0, c};
         if (s > 5'd9) begin
            s = s + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      return r;
   endfunction

   state_t          r_state, w_nxt_state;
   logic [OW-1:0]   r_a, r_b, w_nxt_a, w_nxt_b;
   logic [RW-1:0]   r_r, w_nxt_r;
   logic [1:0]      r_op, w_nxt_op;
   logic            r_neg, w_nxt_neg;
   logic            r_phase, w_nxt_phase;
   logic [IW-1:0]   r_idx, w_nxt_idx;
   logic [3:0]      r_cnt, w_nxt_cnt;
   logic [RW-1:0]   r_disp_bcd, w_nxt_disp;
   logic            r_disp_neg, r_busy;

   key_t            w_kind;
   logic [3:0]      w_digit;
   logic [1:0]      w_kop;
   logic [RW-1:0]   w_add_a, w_add_b, w_sum;
   logic            w_add_sub;
   logic [3:0]      w_bdig;

   // Key strobe decode into digit/operator/enter/backspace classes.
   always_comb begin
      w_kind  = K_NONE;
      w_digit = 4'd0;
      w_kop   = 2'd0;
      if (key_valid) begin
         case (key_code)
            9'h070: begin w_kind = K_DIGIT; w_digit = 4'd0; end
            9'h069: begin w_kind = K_DIGIT; w_digit = 4'd1; end
            9'h072: begin w_kind = K_DIGIT; w_digit = 4'd2; end
            9'h07A: begin w_kind = K_DIGIT; w_digit = 4'd3; end
            9'h06B: begin w_kind = K_DIGIT; w_digit = 4'd4; end
            9'h073: begin w_kind = K_DIGIT; w_digit = 4'd5; end
            9'h074: begin w_kind = K_DIGIT; w_digit = 4'd6; end
            9'h06C: begin w_kind = K_DIGIT; w_digit = 4'd7; end
            9'h075: begin w_kind = K_DIGIT; w_digit = 4'd8; end
            9'h07D: begin w_kind = K_DIGIT; w_digit = 4'd9; end
            9'h079: begin w_kind = K_OP;    w_kop   = 2'd1; end
            9'h07B: begin w_kind = K_OP;    w_kop   = 2'd2; end
            9'h07C: begin w_kind = K_OP;    w_kop   = 2'd3; end
            9'h071: begin w_kind = K_ENTER; end
`ifdef CALC_BACKSPACE_EN
            9'h066: begin w_kind = K_BS;    end
`endif
            default: begin w_kind = K_NONE; end
         endcase
      end else begin
         w_kind = K_NONE;
      end
   end

   // Shared adder operand steering: sub orders operands by the sign found in its first cycle.
   always_comb begin
      w_add_a   = {{OW{1'b0}}, r_a};
      w_add_b   = {{OW{1'b0}}, r_b};
      w_add_sub = 1'b0;
      case (r_op)
         2'd2: begin
            w_add_sub = 1'b1;
            if (r_neg) begin
               w_add_a = {{OW{1'b0}}, r_b};
               w_add_b = {{OW{1'b0}}, r_a};
            end else begin
               w_add_a = {{OW{1'b0}}, r_a};
               w_add_b = {{OW{1'b0}}, r_b};
            end
         end
         2'd3: begin
            w_add_a = r_r;
            w_add_b = {{OW{1'b0}}, r_a};
         end
         default: begin
            w_add_sub = 1'b0;
         end
      endcase
   end

   assign w_sum  = bcd_addsub(w_add_a, w_add_b, w_add_sub);
   assign w_bdig = r_b[4*r_idx +: 4];

   // Next-state and datapath update.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_a     = r_a;
      w_nxt_b     = r_b;
      w_nxt_r     = r_r;
      w_nxt_op    = r_op;
      w_nxt_neg   = r_neg;
      w_nxt_phase = r_phase;
      w_nxt_idx   = r_idx;
      w_nxt_cnt   = r_cnt;
      case (r_state)
         S_ENTER_A: begin
            case (w_kind)
               K_DIGIT: w_nxt_a = {r_a[OW-5:0], w_digit};
               K_BS:    w_nxt_a = r_a >> 4;
               K_OP: begin
                  w_nxt_op    = w_kop;
                  w_nxt_b     = '0;
                  w_nxt_state = S_ENTER_B;
               end
               default: w_nxt_a = r_a;
            endcase
         end
         S_ENTER_B: begin
            case (w_kind)
               K_DIGIT: w_nxt_b  = {r_b[OW-5:0], w_digit};
               K_BS:    w_nxt_b  = r_b >> 4;
               K_OP:    w_nxt_op = w_kop;
               K_ENTER: begin
                  w_nxt_r     = '0;
                  w_nxt_neg   = 1'b0;
                  w_nxt_phase = 1'b0;
                  w_nxt_idx   = IDX_LAST;
                  w_nxt_cnt   = 4'd0;
                  w_nxt_state = S_CALC;
               end
               default: w_nxt_b = r_b;
            endcase
         end
         S_CALC: begin
            case (r_op)
               2'd1: begin
                  w_nxt_r     = w_sum;
                  w_nxt_state = S_SHOW;
               end
               2'd2: begin
                  if (!r_phase) begin
                     w_nxt_neg   = (r_a < r_b);
                     w_nxt_phase = 1'b1;
                  end else begin
                     w_nxt_r     = w_sum;
                     w_nxt_phase = 1'b0;
                     w_nxt_state = S_SHOW;
                  end
               end
               2'd3: begin
                  // phase 0: shift R one digit and load this B digit as the add count
                  if (!r_phase) begin
                     w_nxt_r   = {r_r[RW-5:0], 4'd0};
                     w_nxt_cnt = w_bdig;
                     if (w_bdig != 4'd0) begin
                        w_nxt_phase = 1'b1;
                     end else if (r_idx == '0) begin
                        w_nxt_state = S_SHOW;
                     end else begin
                        w_nxt_idx = r_idx - IDX_ONE;
                     end
                  end else begin
                     w_nxt_r   = w_sum;
                     w_nxt_cnt = r_cnt - 4'd1;
                     if (r_cnt != 4'd1) begin
                        w_nxt_phase = 1'b1;
                     end else if (r_idx == '0) begin
                        w_nxt_phase = 1'b0;
                        w_nxt_state = S_SHOW;
                     end else begin
                        w_nxt_phase = 1'b0;
                        w_nxt_idx   = r_idx - IDX_ONE;
                     end
                  end
               end
               default: w_nxt_state = S_SHOW;
            endcase
         end
         S_SHOW: begin
            case (w_kind)
               K_DIGIT: begin
                  w_nxt_a     = {{(OW-4){1'b0}}, w_digit};
                  w_nxt_b     = '0;
                  w_nxt_op    = 2'd0;
                  w_nxt_neg   = 1'b0;
                  w_nxt_state = S_ENTER_A;
               end
               K_OP: begin
                  if (!r_neg && (r_r[RW-1:OW] == '0)) begin
                     w_nxt_a     = r_r[OW-1:0];
                     w_nxt_op    = w_kop;
                     w_nxt_b     = '0;
                     w_nxt_state = S_ENTER_B;
                  end else begin
                     w_nxt_state = S_SHOW;
                  end
               end
               default: w_nxt_state = S_SHOW;
            endcase
         end
         default: w_nxt_state = S_ENTER_A;
      endcase
   end

   // Display source follows the state being entered.
   always_comb begin
      w_nxt_disp = '0;
      case (w_nxt_state)
         S_ENTER_A:        w_nxt_disp = {{OW{1'b0}}, w_nxt_a};
         S_ENTER_B,
         S_CALC:           w_nxt_disp = {{OW{1'b0}}, w_nxt_b};
         S_SHOW:           w_nxt_disp = w_nxt_r;
         default:          w_nxt_disp = '0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_ENTER_A;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a        <= '0;
         r_b        <= '0;
         r_r        <= '0;
         r_op       <= 2'd0;
         r_neg      <= 1'b0;
         r_phase    <= 1'b0;
         r_idx      <= '0;
         r_cnt      <= 4'd0;
         r_disp_bcd <= '0;
         r_disp_neg <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_a        <= w_nxt_a;
         r_b        <= w_nxt_b;
         r_r        <= w_nxt_r;
         r_op       <= w_nxt_op;
         r_neg      <= w_nxt_neg;
         r_phase    <= w_nxt_phase;
         r_idx      <= w_nxt_idx;
         r_cnt      <= w_nxt_cnt;
         r_disp_bcd <= w_nxt_disp;
         r_disp_neg <= (w_nxt_state == S_SHOW) && w_nxt_neg;
         r_busy     <= (w_nxt_state == S_CALC);
      end
   end

   assign disp_bcd = r_disp_bcd;
   assign disp_neg = r_disp_neg;
   assign disp_op  = r_op;
   assign state    = r_state;
   assign busy     = r_busy;

endmodule

// File: tb/tb_bcd_calc_core.sv
// Directed self-checking bench for bcd_calc_core with DIGITS=2.
module tb_bcd_calc_core;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        key_valid = 1'b0;
   logic [8:0]  key_code  = 9'h000;
   logic [15:0] disp_bcd;
   logic        disp_neg;
   logic [1:0]  disp_op;
   logic [2:0]  state;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   int n_cyc;

   localparam logic [8:0] K_ADD = 9'h079;
   localparam logic [8:0] K_SUB = 9'h07B;
   localparam logic [8:0] K_MUL = 9'h07C;
   localparam logic [8:0] K_ENT = 9'h071;
   localparam logic [8:0] K_BS  = 9'h066;
   logic [8:0] dk [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                           9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

   bcd_calc_core #(.DIGITS(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_valid(key_valid),
      .key_code (key_code),
      .disp_bcd (disp_bcd),
      .disp_neg (disp_neg),
      .disp_op  (disp_op),
      .state    (state),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [8:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 9'h000;
   endtask

   task automatic dig(input int d);
      press(dk[d]);
   endtask

   task automatic wait_show(output int n);
      n = 0;
      while (state !== 3'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_disp", disp_bcd, 16'h0000);
      chk("rst_neg", disp_neg, 1'b0);
      chk("rst_op", disp_op, 2'd0);
      chk("rst_state", state, 3'd0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;

      // 12 + 34
      dig(1); dig(2);
      chk("a_12", disp_bcd, 16'h0012);
      press(K_ADD);
      chk("opA_state", state, 3'd1);
      chk("opA_op", disp_op, 2'd1);
      chk("opA_disp", disp_bcd, 16'h0000);
      dig(3); dig(4);
      chk("b_34", disp_bcd, 16'h0034);
      press(K_ENT);
      chk("add_calc", state, 3'd2);
      chk("add_busy", busy, 1'b1);
      @(negedge clk);
      chk("add_show", state, 3'd3);
      chk("add_busy0", busy, 1'b0);
      chk("add_res", disp_bcd, 16'h0046);
      chk("add_op", disp_op, 2'd1);
      chk("add_neg", disp_neg, 1'b0);

      // chain: 46 - 50
      press(K_SUB);
      chk("chain_state", state, 3'd1);
      chk("chain_op", disp_op, 2'd2);
      dig(5); dig(0);
      press(K_ENT);
      chk("chain_c1", state, 3'd2);
      @(negedge clk);
      chk("chain_c2", state, 3'd2);
      @(negedge clk);
      chk("chain_show", state, 3'd3);
      chk("chain_res", disp_bcd, 16'h0004);
      chk("chain_neg", disp_neg, 1'b1);
      press(K_ADD);
      chk("negop_state", state, 3'd3);
      chk("negop_op", disp_op, 2'd2);
      chk("negop_disp", disp_bcd, 16'h0004);
      dig(7);
      chk("show_dig_state", state, 3'd0);
      chk("show_dig_disp", disp_bcd, 16'h0007);
      chk("show_dig_op", disp_op, 2'd0);
      chk("show_dig_neg", disp_neg, 1'b0);

      // 25 - 73
      dig(2); dig(5);
      chk("a_25", disp_bcd, 16'h0025);
      press(K_SUB); dig(7); dig(3);
      press(K_ENT);
      wait_show(n_cyc);
      chk("sub_lat", n_cyc, 2);
      chk("sub_res", disp_bcd, 16'h0048);
      chk("sub_neg", disp_neg, 1'b1);

      // 1,2,3 -> 23
      dig(1); dig(2); dig(3);
      chk("a_23", disp_bcd, 16'h0023);

      // 99 * 99, operator replaced in ENTER_B
      dig(9); dig(9);
      press(K_ADD); press(K_MUL);
      chk("op_replace", disp_op, 2'd3);
      dig(9); dig(9);
      press(K_ENT);
      wait_show(n_cyc);
      chk("mul99_lat", n_cyc, 20);
      chk("mul99_res", disp_bcd, 16'h9801);
      chk("mul99_neg", disp_neg, 1'b0);

      // 12 * 34 with a digit key held through CALC incl. the completion edge
      dig(1); dig(2);
      press(K_MUL); dig(3); dig(4);
      press(K_ENT);
      key_valid = 1'b1;
      key_code  = dk[5];
      repeat (8) @(negedge clk);
      chk("mul12_pre", state, 3'd2);
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 9'h000;
      chk("mul12_show", state, 3'd3);
      chk("mul12_res", disp_bcd, 16'h0408);
      press(K_ENT);
      chk("show_ent", state, 3'd3);
      chk("show_ent_res", disp_bcd, 16'h0408);

      // reset mid-CALC
      dig(5); press(K_MUL); dig(9);
      press(K_ENT);
      repeat (3) @(negedge clk);
      chk("midcalc_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_disp", disp_bcd, 16'h0000);
      chk("arst_state", state, 3'd0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_op", disp_op, 2'd0);
      chk("arst_neg", disp_neg, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_state", state, 3'd0);
      chk("post_rst_disp", disp_bcd, 16'h0000);

      // Backspace
      dig(1); dig(2); press(K_BS); dig(5);
`ifdef CALC_BACKSPACE_EN
      chk("bs_a", disp_bcd, 16'h0015);
`else
      chk("bs_a", disp_bcd, 16'h0025);
`endif
      chk("bs_state", state, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
